// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator
//
// Multi-cycle magnitude comparator. Operands are captured on an accepted start
// and compared one DIGIT-bit slice per cycle, most-significant digit first. The
// first differing digit fixes the decision. The decision is published on three
// mutually exclusive flags together with a one-cycle done pulse.
//
// Parameters:
//   WIDTH  - operand width; >= 2 and a multiple of DIGIT
//   DIGIT  - bits examined per RUN cycle; N = WIDTH/DIGIT digits
//   SIGNED - 0: unsigned compare, 1: two's-complement compare
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high reset
//   start  - request, sampled only in IDLE
//   a, b   - operands, captured on the accepted start
//   busy   - high in RUN and DONE
//   done   - one-cycle pulse; result flags update in the same cycle
//   agrb   - A > B
//   aeqb   - A == B
//   alsb   - A < B
//
// Build option:
//   EARLY_TERM_EN - when defined, RUN exits in the cycle the first differing
//                   digit is found; otherwise all N digits are always examined.

module seq_magnitude_comparator #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGIT  = 2,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             agrb,
  output logic             aeqb,
  output logic             alsb
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             gt_q, gt_d, lt_q, lt_d;
  logic             agrb_q, agrb_d, aeqb_q, aeqb_d, alsb_q, alsb_d;

  logic [DIGIT-1:0] a_dig, b_dig;
  logic             dig_gt, dig_lt, gt_next, lt_next, run_exit;

  // Operands are shifted left each RUN cycle, so the digit under test is always
  // the top slice. This walks index N-1 down to 0 without a variable mux.
  assign a_dig = a_q[WIDTH-1 -: DIGIT];
  assign b_dig = b_q[WIDTH-1 -: DIGIT];

  always_comb begin
    dig_gt  = (a_dig > b_dig);
    dig_lt  = (a_dig < b_dig);
    // A fixed decision is never overturned by a later digit.
    gt_next = gt_q | (~lt_q & dig_gt);
    lt_next = lt_q | (~gt_q & dig_lt);
`ifdef EARLY_TERM_EN
    run_exit = (idx_q == '0) | dig_gt | dig_lt;
`else
    run_exit = (idx_q == '0);
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (run_exit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
    agrb = agrb_q;
    aeqb = aeqb_q;
    alsb = alsb_q;
  end

  // Datapath next-state
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    idx_d  = idx_q;
    gt_d   = gt_q;
    lt_d   = lt_q;
    agrb_d = agrb_q;
    aeqb_d = aeqb_q;
    alsb_d = alsb_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          // Flipping the sign bit at capture turns a two's-complement compare
          // into an unsigned one on the most-significant digit.
          a_d   = {a[WIDTH-1] ^ SIGNED, a[WIDTH-2:0]};
          b_d   = {b[WIDTH-1] ^ SIGNED, b[WIDTH-2:0]};
          idx_d = LastIdx;
          gt_d  = 1'b0;
          lt_d  = 1'b0;
        end
      end
      StRun: begin
        a_d  = a_q << DIGIT;
        b_d  = b_q << DIGIT;
        gt_d = gt_next;
        lt_d = lt_next;
        if (idx_q != '0) idx_d = idx_q - IdxW'(1);
        // Flags are loaded on the RUN exit edge so they are valid with done.
        if (run_exit) begin
          agrb_d = gt_next;
          alsb_d = lt_next;
          aeqb_d = ~(gt_next | lt_next);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      idx_q  <= '0;
      gt_q   <= 1'b0;
      lt_q   <= 1'b0;
      agrb_q <= 1'b0;
      aeqb_q <= 1'b0;
      alsb_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      idx_q  <= idx_d;
      gt_q   <= gt_d;
      lt_q   <= lt_d;
      agrb_q <= agrb_d;
      aeqb_q <= aeqb_d;
      alsb_q <= alsb_d;
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Testbench for seq_magnitude_comparator.
// Three instances: dut0 (8/2 unsigned), dut1 (8/2 signed), dut2 (2/1 unsigned).
// Stimulus pushes expected {done cycle, flags} into a per-instance queue; a
// negedge monitor pops and compares whenever done is seen.

module tb_seq_magnitude_comparator;

  logic clk, reset;
  logic start0, start1, start2;
  logic [7:0] a0, b0, a1, b1;
  logic [1:0] a2, b2;
  logic busy0, done0, agrb0, aeqb0, alsb0;
  logic busy1, done1, agrb1, aeqb1, alsb1;
  logic busy2, done2, agrb2, aeqb2, alsb2;

  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(2), .SIGNED(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .a(a0), .b(b0), .busy(busy0),
    .done(done0), .agrb(agrb0), .aeqb(aeqb0), .alsb(alsb0));
  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(2), .SIGNED(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .busy(busy1),
    .done(done1), .agrb(agrb1), .aeqb(aeqb1), .alsb(alsb1));
  seq_magnitude_comparator #(.WIDTH(2), .DIGIT(1), .SIGNED(1'b0)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .busy(busy2),
    .done(done2), .agrb(agrb2), .aeqb(aeqb2), .alsb(alsb2));

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  res;  // {gt, eq, lt}
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int   acc[3], free[3];
  logic [2:0] held[3];
  int   cyc = 0;
  int   n_vec = 0, n_err = 0;
  bit   chk_en = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic int pw(input int id); return (id == 2) ? 2 : 8; endfunction
  function automatic int pd(input int id); return (id == 2) ? 1 : 2; endfunction

  function automatic logic [2:0] ref_res(input int id, input logic [7:0] av,
                                         input logic [7:0] bv);
    int w, x, y;
    w = pw(id);
    x = int'(av) & ((1 << w) - 1);
    y = int'(bv) & ((1 << w) - 1);
    if (id == 1) begin
      if (x >= (1 << (w - 1))) x = x - (1 << w);
      if (y >= (1 << (w - 1))) y = y - (1 << w);
    end
    if (x > y) return 3'b100;
    if (x == y) return 3'b010;
    return 3'b001;
  endfunction

  // Cycles from the accepting IDLE cycle to the done cycle.
  function automatic int ref_lat(input int id, input logic [7:0] av, input logic [7:0] bv);
    int w, d, n, x;
    w = pw(id);
    d = pd(id);
    n = w / d;
    x = int'(av ^ bv) & ((1 << w) - 1);
`ifdef EARLY_TERM_EN
    for (int k = 1; k <= n; k++) begin
      if (((x >> (w - k * d)) & ((1 << d) - 1)) != 0) return k + 1;
    end
`else
    if (x < 0) return 0;
`endif
    return n + 1;
  endfunction

  // ---------------- queue helpers ----------------
  function automatic int qsz(input int id);
    case (id)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qfront(input int id);
    case (id)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int id, output exp_t e);
    case (id)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic qpush(input int id, input exp_t e);
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input int id, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h", name, id, cyc, act, req);
    end
  endtask

  task automatic mon(input int id, input logic dn, input logic bz, input logic [2:0] fl);
    exp_t e;
    chk("busy", id, int'(bz), int'(cyc > acc[id] && cyc < free[id]));
    if (qsz(id) > 0) begin
      e = qfront(id);
      if (int'(e.cyc) < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL done_missing dut%0d cycle %0d: got no done, expected done in cycle %0d",
                 id, cyc, e.cyc);
        qpop(id, e);
      end
    end
    if (dn) begin
      if (qsz(id) == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL done_unexpected dut%0d cycle %0d: got done=1, expected done=0", id, cyc);
      end else begin
        qpop(id, e);
        chk("done_cycle", id, cyc, int'(e.cyc));
        held[id] = e.res;
      end
    end
    chk("flags", id, int'(fl), int'(held[id]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      mon(0, done0, busy0, {agrb0, aeqb0, alsb0});
      mon(1, done1, busy1, {agrb1, aeqb1, alsb1});
      mon(2, done2, busy2, {agrb2, aeqb2, alsb2});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
    start0 = 0;
    start1 = 0;
    start2 = 0;
  endtask

  // Drive one instance for the current cycle; model acceptance in IDLE only.
  task automatic set(input int id, input logic st, input logic [7:0] av, input logic [7:0] bv);
    exp_t e;
    int l;
    case (id)
      0: begin start0 = st; a0 = av; b0 = bv; end
      1: begin start1 = st; a1 = av; b1 = bv; end
      default: begin start2 = st; a2 = av[1:0]; b2 = bv[1:0]; end
    endcase
    if (st && cyc >= free[id]) begin
      l = ref_lat(id, av, bv);
      e.cyc = 32'(cyc + l);
      e.res = ref_res(id, av, bv);
      qpush(id, e);
      acc[id]  = cyc;
      free[id] = cyc + l + 1;
    end
  endtask

  task automatic wait_idle(input int id);
    for (int i = 0; i < 40 && cyc < free[id]; i++) step();
  endtask

  task automatic do_reset();
    reset = 1;
    step();
    reset = 0;
    q0.delete();
    q1.delete();
    q2.delete();
    for (int i = 0; i < 3; i++) begin
      acc[i]  = cyc;
      free[i] = cyc;
      held[i] = 3'b000;
    end
    chk_en = 1;
  endtask

  initial begin
    logic [7:0] ra, rb;
    reset = 1;
    start0 = 0; start1 = 0; start2 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0; a2 = 0; b2 = 0;
    for (int i = 0; i < 3; i++) begin
      acc[i] = 0; free[i] = 0; held[i] = 3'b000;
    end
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    step();

    // Equal operands, then flags held for a while.
    set(0, 1, 8'h5A, 8'h5A);
    step();
    wait_idle(0);
    repeat (3) step();

    set(0, 1, 8'hC3, 8'h43);
    step();
    wait_idle(0);

    // Unsigned vs signed interpretation.
    set(0, 1, 8'hFF, 8'h01);
    set(1, 1, 8'hFF, 8'h01);
    step();
    wait_idle(0);
    wait_idle(1);
    set(1, 1, 8'h80, 8'h7F);
    step();
    wait_idle(1);

    // Start pulsed while busy is ignored.
    set(0, 1, 8'h21, 8'h2C);
    step();
    step();
    set(0, 1, 8'h00, 8'hFF);
    step();
    set(0, 1, 8'hFF, 8'h00);
    step();
    wait_idle(0);
    step();

    // Reset in cycle 2 aborts: no done, flags cleared.
    set(0, 1, 8'h12, 8'h34);
    step();
    step();
    do_reset();
    repeat (8) step();

    // Start held high for 20 cycles with changing operands.
    for (int i = 0; i < 20; i++) begin
      set(0, 1, 8'($urandom), 8'($urandom));
      step();
    end
    wait_idle(0);

    // All 16 pairs on the 2-bit instance.
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        wait_idle(2);
        set(2, 1, 8'(x), 8'(y));
        step();
      end
    end
    wait_idle(2);

    // Random traffic on all instances at once.
    for (int i = 0; i < 400; i++) begin
      for (int id = 0; id < 3; id++) begin
        ra = 8'($urandom);
        rb = ($urandom_range(0, 2) == 0) ? (ra ^ (8'h1 << $urandom_range(0, 7))) : 8'($urandom);
        if ($urandom_range(0, 4) == 0) rb = ra;
        set(id, ($urandom_range(0, 2) != 0), ra, rb);
      end
      step();
    end

    repeat (20) step();
    chk("drain", 0, qsz(0), 0);
    chk("drain", 1, qsz(1), 0);
    chk("drain", 2, qsz(2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_comparator.md
# seq_magnitude_comparator

Multi-cycle, parametrised magnitude comparator. It replaces fixed-width combinational greater-than blocks wherever wide operands would make a flat sum-of-products too large. Operands are captured on a start pulse and compared one digit per cycle, most-significant digit first. Mutually exclusive greater, equal and less flags are produced with a one-cycle done pulse. Unsigned or two's-complement operation is selected by parameter.

## Interface
- WIDTH, 8, operand width in bits; must be ≥2 and a multiple of DIGIT.
- DIGIT, 2, bits examined per RUN cycle; ≥1. N = WIDTH/DIGIT digits.
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.

Ports:
- clk  in  1  rising-edge clock; only clock in the block.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on the accepted start.
- b  in  WIDTH  operand B; captured on the accepted start.
- busy  out  1  high in RUN and DONE states.
- done  out  1  one-cycle pulse; result flags update in the same cycle.
- agrb  out  1  A > B.
- aeqb  out  1  A == B.
- alsb  out  1  A < B.

## Operation
- FSM states: IDLE → RUN → DONE → IDLE.
- IDLE: start=1 captures a and b into internal registers, sets digit index to N-1, clears the internal decision, and moves to RUN. start=0 stays in IDLE.
- RUN, one digit per cycle, index N-1 down to 0:
  - Compare a_reg and b_reg digit slices as unsigned values.
  - SIGNED=1 and index N-1: invert bit WIDTH-1 of both operands before comparing. This makes a negative operand compare smaller.
  - The first differing digit fixes the decision (GT or LT). Later digits never change a fixed decision.
- RUN exit: after digit 0, or earlier per EARLY_TERM_EN (see Configuration). If no digit differed, the decision is EQ.
- DONE: lasts exactly one cycle. done=1. agrb/aeqb/alsb are loaded from the decision. Next state is IDLE.
- Result flags hold their value until the next done or reset. After the first done, exactly one flag is high.
- start while busy=1 is ignored. It is not queued.
- a and b may change freely after capture without affecting the result.

## Timing
- Reset values: state=IDLE; busy=0, done=0, agrb=0, aeqb=0, alsb=0; internal registers cleared.
- Reset asserted in any state takes effect at the next edge. It aborts the operation: no done pulse, flags return to 0.
- Cycle 0 is the IDLE cycle with start=1. RUN occupies cycles 1..N (cycle k examines digit N-k). DONE is cycle N+1.
- Full latency is start-to-done N+1 cycles. busy is high in cycles 1..N+1.
- The earliest next accepted start is cycle N+2, the IDLE cycle. A continuously held start therefore launches one operation every N+2 cycles.
- Early exit (macro defined): if digit N-k differs in cycle k, DONE is cycle k+1. The minimum latency is 2 cycles.

## Configuration
- EARLY_TERM_EN defined: RUN exits in the cycle the first differing digit is found. Latency varies from 2 to N+1 cycles.
- EARLY_TERM_EN undefined: RUN always processes all N digits. Latency is fixed at N+1 cycles, independent of data. Results are identical in both builds; only done timing differs.

## Test plan
All scenarios use WIDTH=8, DIGIT=2, SIGNED=0 unless stated; N=4.
- Reset, then start with a=8'h5A, b=8'h5A → busy high cycles 1–5, done in cycle 5, aeqb=1, agrb=0, alsb=0; flags held afterwards.
- a=8'hC3, b=8'h43 → agrb=1. With EARLY_TERM_EN: done in cycle 2. Without it: done in cycle 5.
- a=8'hFF, b=8'h01 → SIGNED=0 gives agrb=1; SIGNED=1 gives alsb=1. Also a=8'h80, b=8'h7F with SIGNED=1 → alsb=1.
- Start pulsed in cycles 2 and 3 of an operation → ignored, single done. Reset in cycle 2 → cycle 3 shows busy=0 and all flags 0; no done ever appears.
- start held high for 20 cycles with EARLY_TERM_EN undefined → done in cycles 5, 11 and 17; each result matches the operands present at its accepting IDLE cycle.
- WIDTH=2, DIGIT=1, all 16 (a,b) pairs, unsigned → agrb equals (a>b), aeqb equals (a==b), alsb equals (a<b) for every pair.
